fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_sequencer_if
// Brief  : PC, instruction-memory, redirect and downstream signals of the fetch sequencer
// Rev    : 1.0  initial release
// ============================================================================
interface fetch_sequencer_if;
    // Program counter
    logic [15:0] pcAddress;
    logic        pcWrite;
    logic [15:0] nextAddress;
    // Instruction memory
    logic        memReadReq;
    logic [15:0] memAddress;
    logic        memReady;
    logic [15:0] memData;
    // Redirect
    logic        branchTaken;
    logic [15:0] branchTarget;
    // Downstream
    logic        instrValid;
    logic [15:0] instruction;
    logic [15:0] instrAddress;
    logic        instrAccept;
    logic        stall;

    modport master (
        input  pcAddress,
        output pcWrite,
        output nextAddress,
        output memReadReq,
        output memAddress,
        input  memReady,
        input  memData,
        input  branchTaken,
        input  branchTarget,
        output instrValid,
        output instruction,
        output instrAddress,
        input  instrAccept,
        input  stall
    );

    modport slave (
        output pcAddress,
        input  pcWrite,
        input  nextAddress,
        input  memReadReq,
        input  memAddress,
        output memReady,
        output memData,
        output branchTaken,
        output branchTarget,
        input  instrValid,
        input  instruction,
        input  instrAddress,
        output instrAccept,
        output stall
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fetch_sequencer
// Brief  : single-outstanding instruction fetch with PC update and branch redirect
// Rev    : 1.0  initial release
// ============================================================================
module fetch_sequencer (
    input  logic              clock,
    input  logic              reset_n,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQUEST  = 2'd1,
        S_HOLD     = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [15:0] C_PC_STEP = 16'd2;

    state_t      state_q, state_d;
    logic        pc_write_q, pc_write_d;
    logic [15:0] next_addr_q, next_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [15:0] instruction_q, instruction_d;
    logic [15:0] instr_addr_q, instr_addr_d;
    logic        w_request;

    // Request decodes from the async-reset state, so reset drops it immediately.
    assign w_request      = (state_q == S_REQUEST);
    assign bus.memReadReq = w_request;
    assign bus.memAddress = w_request ? bus.pcAddress : 16'h0000;

    assign bus.pcWrite      = pc_write_q;
    assign bus.nextAddress  = next_addr_q;
    assign bus.instrValid   = instr_valid_q;
    assign bus.instruction  = instruction_q;
    assign bus.instrAddress = instr_addr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pc_write_q    <= 1'b0;
            next_addr_q   <= 16'h0000;
            instr_valid_q <= 1'b0;
            instruction_q <= 16'h0000;
            instr_addr_q  <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_write_q    <= pc_write_d;
            next_addr_q   <= next_addr_d;
            instr_valid_q <= instr_valid_d;
            instruction_q <= instruction_d;
            instr_addr_q  <= instr_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write_d    = 1'b0;
        next_addr_d   = next_addr_q;
        instr_valid_d = instr_valid_q;
        instruction_d = instruction_q;
        instr_addr_d  = instr_addr_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQUEST;
            end
            S_REQUEST: begin
                // A redirect wins over a completing read; that read's data is discarded.
                if (bus.branchTaken) begin
                    pc_write_d    = 1'b1;
                    next_addr_d   = bus.branchTarget;
                    instr_valid_d = 1'b0;
                    state_d       = S_REDIRECT;
                end else if (bus.memReady) begin
                    instruction_d = bus.memData;
                    instr_addr_d  = bus.pcAddress;
                    instr_valid_d = 1'b1;
                    pc_write_d    = 1'b1;
                    next_addr_d   = bus.pcAddress + C_PC_STEP;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.branchTaken) begin
                    pc_write_d    = 1'b1;
                    next_addr_d   = bus.branchTarget;
                    instr_valid_d = 1'b0;
                    state_d       = S_REDIRECT;
                end else if (bus.instrAccept && !bus.stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQUEST;
                end
            end
            S_REDIRECT: begin
                // One quiet cycle lets the PC load land before the next read.
                state_d = S_REQUEST;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_sequencer
// Brief  : scoreboard bench for fetch_sequencer with a behavioural PC and memory
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    logic [15:0] pc_q;
    logic        pc_preset;
    logic [15:0] pc_preset_val;
    logic        prev_valid;

    logic [15:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];

    fetch_sequencer_if ifc ();

    fetch_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program counter model: loads nextAddress on pcWrite, or a bench preset.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pc_q <= 16'h0000;
        else if (pc_preset)
            pc_q <= pc_preset_val;
        else if (ifc.pcWrite)
            pc_q <= ifc.nextAddress;
    end
    assign ifc.pcAddress = pc_q;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a PC load or a new instruction.
    always @(negedge clock) begin
        if (reset_n) begin
            if (ifc.pcWrite) begin
                if (exp_pc_q.size() == 0) begin
                    chk("pcw_unexpected", ifc.nextAddress, 16'hxxxx);
                end else begin
                    chk("nextAddress", ifc.nextAddress, exp_pc_q.pop_front());
                end
            end
            if (ifc.instrValid && !prev_valid) begin
                if (exp_instr_q.size() == 0) begin
                    chk("instr_unexpected", ifc.instruction, 16'hxxxx);
                end else begin
                    logic [31:0] e;
                    e = exp_instr_q.pop_front();
                    chk("instruction", ifc.instruction, e[31:16]);
                    chk("instrAddress", ifc.instrAddress, e[15:0]);
                end
            end
            if (ifc.instrValid && ifc.memReadReq)
                chk("req_while_valid", 16'(ifc.memReadReq), 16'h0000);
            prev_valid <= ifc.instrValid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    // Called at a negedge in REQUEST with pcAddress == addr; returns at a negedge in HOLD.
    task automatic fetch(input logic [15:0] data, input int waits,
                         input logic [15:0] addr, input logic [15:0] exp_next);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", 16'(ifc.memReadReq), 16'h0001);
            chk("wait_addr", ifc.memAddress, addr);
            ifc.memReady = 1'b0;
            step();
        end
        chk("req", 16'(ifc.memReadReq), 16'h0001);
        chk("req_addr", ifc.memAddress, addr);
        ifc.memReady = 1'b1;
        ifc.memData  = data;
        exp_pc_q.push_back(exp_next);
        exp_instr_q.push_back({data, addr});
        step();
        ifc.memReady = 1'b0;
        ifc.memData  = 16'h0000;
        chk("hold_valid", 16'(ifc.instrValid), 16'h0001);
        chk("hold_noreq", 16'(ifc.memReadReq), 16'h0000);
        chk("hold_addr0", ifc.memAddress, 16'h0000);
    endtask

    // Called at a negedge in HOLD; consumes the instruction, optionally presetting the PC.
    task automatic accept(input logic use_preset, input logic [15:0] newpc);
        ifc.instrAccept = 1'b1;
        pc_preset       = use_preset;
        pc_preset_val   = newpc;
        step();
        ifc.instrAccept = 1'b0;
        pc_preset       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        pc_preset       = 1'b0;
        pc_preset_val   = 16'h0000;
        ifc.memReady    = 1'b0;
        ifc.memData     = 16'h0000;
        ifc.branchTaken = 1'b0;
        ifc.branchTarget= 16'h0000;
        ifc.instrAccept = 1'b0;
        ifc.stall       = 1'b0;
        reset_n         = 1'b0;
        ifc.memReady    = 1'b1;
        repeat (3) step();
        chk("rst_pcWrite", 16'(ifc.pcWrite), 16'h0000);
        chk("rst_nextAddress", ifc.nextAddress, 16'h0000);
        chk("rst_memReadReq", 16'(ifc.memReadReq), 16'h0000);
        chk("rst_memAddress", ifc.memAddress, 16'h0000);
        chk("rst_instrValid", 16'(ifc.instrValid), 16'h0000);
        chk("rst_instruction", ifc.instruction, 16'h0000);
        chk("rst_instrAddress", ifc.instrAddress, 16'h0000);
        ifc.memReady = 1'b0;
        reset_n      = 1'b1;
        chk("idle_noreq", 16'(ifc.memReadReq), 16'h0000);
        step();

        // Basic fetch at 0000
        fetch(16'h1234, 0, 16'h0000, 16'h0002);
        accept(1'b1, 16'hAAAA);

        // Three wait states at AAAA
        fetch(16'h5678, 3, 16'hAAAA, 16'hAAAC);
        ifc.stall       = 1'b1;
        ifc.instrAccept = 1'b1;
        step();
        chk("pcw_single", 16'(ifc.pcWrite), 16'h0000);
        for (int i = 0; i < 2; i++) begin
            chk("stall_valid", 16'(ifc.instrValid), 16'h0001);
            chk("stall_data", ifc.instruction, 16'h5678);
            chk("stall_noreq", 16'(ifc.memReadReq), 16'h0000);
            if (i == 0) step();
        end
        ifc.stall = 1'b0;
        step();
        ifc.instrAccept = 1'b0;
        chk("acc_valid", 16'(ifc.instrValid), 16'h0000);
        chk("acc_req", 16'(ifc.memReadReq), 16'h0001);
        chk("acc_addr", ifc.memAddress, 16'hAAAC);

        // Branch racing a completing read
        ifc.memReady     = 1'b1;
        ifc.memData      = 16'hDEAD;
        ifc.branchTaken  = 1'b1;
        ifc.branchTarget = 16'hBBBB;
        exp_pc_q.push_back(16'hBBBB);
        step();
        ifc.memReady    = 1'b0;
        ifc.branchTaken = 1'b0;
        chk("redir_valid", 16'(ifc.instrValid), 16'h0000);
        chk("redir_noreq", 16'(ifc.memReadReq), 16'h0000);
        chk("redir_keep_instr", ifc.instruction, 16'h5678);
        ifc.branchTaken = 1'b1;
        ifc.branchTarget= 16'h4444;
        step();
        ifc.branchTaken = 1'b0;
        chk("post_redir_req", 16'(ifc.memReadReq), 16'h0001);
        chk("post_redir_addr", ifc.memAddress, 16'hBBBB);

        // Branch racing instrAccept in HOLD
        fetch(16'hCAFE, 0, 16'hBBBB, 16'hBBBD);
        ifc.instrAccept  = 1'b1;
        ifc.branchTaken  = 1'b1;
        ifc.branchTarget = 16'h1000;
        exp_pc_q.push_back(16'h1000);
        step();
        ifc.instrAccept = 1'b0;
        ifc.branchTaken = 1'b0;
        chk("hbr_valid", 16'(ifc.instrValid), 16'h0000);
        chk("hbr_noreq", 16'(ifc.memReadReq), 16'h0000);
        step();
        chk("hbr_addr", ifc.memAddress, 16'h1000);

        // PC wrap at FFFE
        fetch(16'h0F0F, 0, 16'h1000, 16'h1002);
        accept(1'b1, 16'hFFFE);
        fetch(16'h7777, 1, 16'hFFFE, 16'h0000);
        accept(1'b0, 16'h0000);
        chk("wrap_addr", ifc.memAddress, 16'h0000);

        // Asynchronous reset mid-request
        #2;
        reset_n      = 1'b0;
        ifc.memReady = 1'b1;
        ifc.memData  = 16'h9999;
        #1;
        chk("arst_noreq", 16'(ifc.memReadReq), 16'h0000);
        chk("arst_addr", ifc.memAddress, 16'h0000);
        chk("arst_valid", 16'(ifc.instrValid), 16'h0000);
        chk("arst_instr", ifc.instruction, 16'h0000);
        step();
        step();
        ifc.memReady = 1'b0;
        reset_n      = 1'b1;
        chk("arst_idle", 16'(ifc.memReadReq), 16'h0000);
        step();
        chk("arst_req", 16'(ifc.memReadReq), 16'h0001);
        chk("arst_req_addr", ifc.memAddress, 16'h0000);
        step();

        chk("pc_queue_empty", 16'(exp_pc_q.size()), 16'h0000);
        chk("instr_queue_empty", 16'(exp_instr_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
